// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;

    typedef logic [2:0] req_id_t;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    function automatic logic [N_REQ-1:0] id_to_onehot(req_id_t id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/or8way.sv
// Eight-input OR reduction gate.
module or8way (
    input  logic [7:0] a,
    output logic       y
);

    assign y = |a;

endmodule

// File: rtl/rr_pick8.sv
// Combinational rotating priority picker: first set bit of req scanning from start upward mod 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_id_t          start,
    output logic             found,
    output req_id_t          id
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    always_comb begin
        dbl   = {req, req} >> start;
        rot   = dbl[N_REQ-1:0];
        found = 1'b0;
        id    = start;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                id    = start + req_id_t'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and optional hold timeout.
module rr_arb8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output req_id_t          gnt_id,
    output logic             preempt
);

    localparam int unsigned CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CW'(HOLD_MAX - 1);

    arb_state_t       state_q, state_d;
    req_id_t          ptr_q, ptr_d;
    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    req_id_t          gnt_id_q, gnt_id_d;
    logic             preempt_q, preempt_d;

    logic    any_req;
    logic    pick_found;
    req_id_t pick_id;
    req_id_t pick_start;
    req_id_t next_id;
    logic    timeout;

    or8way u_or8way (
        .a (req),
        .y (any_req)
    );

    assign next_id    = gnt_id_q + 3'd1;
    assign pick_start = (state_q == IDLE) ? ptr_q : next_id;

    rr_pick8 u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .id    (pick_id)
    );

    assign timeout = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        preempt_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d      = id_to_onehot(pick_id);
                    gnt_id_d   = pick_id;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    ptr_d = next_id;
                    if (any_req && pick_found) begin
                        gnt_d      = id_to_onehot(pick_id);
                        gnt_id_d   = pick_id;
                        hold_cnt_d = '0;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (timeout) begin
                    // Holder still requests, so the picker always finds someone (possibly itself).
                    ptr_d      = next_id;
                    preempt_d  = 1'b1;
                    gnt_d      = id_to_onehot(pick_id);
                    gnt_id_d   = pick_id;
                    hold_cnt_d = '0;
                end else if (HOLD_MAX != 0) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            preempt_q  <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed self-checking bench for rr_arb8 with HOLD_MAX=4.
module tb_rr_arb8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic       preempt;

    int n_checks = 0;
    int n_errors = 0;

    rr_arb8 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 8'h00;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic expect_out(string name, logic [7:0] e_gnt, logic [2:0] e_id, logic e_pre);
        n_checks++;
        if (gnt !== e_gnt || gnt_valid !== (|e_gnt) || gnt_id !== e_id || preempt !== e_pre) begin
            n_errors++;
            $display("FAIL %s: gnt=%h valid=%b id=%0d pre=%b, required gnt=%h valid=%b id=%0d pre=%b",
                     name, gnt, gnt_valid, gnt_id, preempt, e_gnt, |e_gnt, e_id, e_pre);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("reset_idle", 8'h00, 3'd0, 1'b0);
        end
        rst = 1'b0;
        step();
        expect_out("idle_after_reset", 8'h00, 3'd0, 1'b0);
        req = 8'h08;
        step();
        expect_out("grant_before_async_rst", 8'h08, 3'd3, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst_clears", 8'h00, 3'd0, 1'b0);
        #1;
        rst = 1'b0;
        req = 8'h00;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h08;
        step();
        expect_out("single_grant", 8'h08, 3'd3, 1'b0);
        req = 8'h0F;
        step();
        expect_out("single_hold_new_reqs", 8'h08, 3'd3, 1'b0);
        req = 8'h00;
        step();
        expect_out("single_release", 8'h00, 3'd3, 1'b0);
        // ptr is now 4: of requesters 0 and 3, 0 comes first in the scan.
        req = 8'h09;
        step();
        expect_out("single_ptr_after_release", 8'h01, 3'd0, 1'b0);
        req = 8'h00;
        step();
    endtask

    task automatic test_round_robin();
        logic [7:0] drop;
        do_reset();
        req = 8'hFF;
        step();
        expect_out("rr_first", 8'h01, 3'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            drop = 8'h01 << ((k - 1) % 8);
            req  = 8'hFF & ~drop;
            step();
            expect_out("rr_handoff", 8'h01 << (k % 8), 3'(k % 8), 1'b0);
        end
        req = 8'h00;
        step();
        expect_out("rr_idle", 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_wrap_skip();
        do_reset();
        req = 8'h20;
        step();
        expect_out("wrap_setup", 8'h20, 3'd5, 1'b0);
        req = 8'h00;
        step();
        req = 8'h41;
        step();
        expect_out("wrap_ptr6", 8'h40, 3'd6, 1'b0);
        req = 8'h01;
        step();
        expect_out("wrap_to_0", 8'h01, 3'd0, 1'b0);
        req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h05;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i <= 4)      expect_out("to_hold0", 8'h01, 3'd0, 1'b0);
            else if (i == 5) expect_out("to_preempt_to2", 8'h04, 3'd2, 1'b1);
            else if (i <= 8) expect_out("to_hold2", 8'h04, 3'd2, 1'b0);
            else             expect_out("to_preempt_to0", 8'h01, 3'd0, 1'b1);
        end
        req = 8'h01;
        for (int i = 10; i <= 17; i++) begin
            step();
            expect_out("to_sole_regrant", 8'h01, 3'd0, (i == 13 || i == 17));
        end
        req = 8'h00;
        step();
        expect_out("to_release", 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_collision();
        do_reset();
        req = 8'h03;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("coll_hold", 8'h01, 3'd0, 1'b0);
        end
        req = 8'h02;
        step();
        expect_out("coll_release_wins", 8'h02, 3'd1, 1'b0);
        req = 8'h00;
        step();
        expect_out("coll_idle", 8'h00, 3'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_timeout();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
- Round-robin arbiter sharing one resource (e.g. a bus, RAM port or ALU slot) among 8 requesters.
- Detects pending requests with the existing or8way gate.
- Issues a registered one-hot grant and holds it while the winner keeps its request high.
- Rotates priority on release; optionally preempts a requester that holds the grant too long.

Parameters:
- HOLD_MAX, 16: maximum consecutive GRANT cycles before forced preemption; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request vector; bit i = requester i.
- gnt  output 8  one-hot grant, registered.
- gnt_valid  output 1  high when any gnt bit is set.
- gnt_id  output 3  binary index of the granted requester; holds its last value when gnt_valid=0.
- preempt  output 1  one-cycle pulse on a timeout-forced handoff.

Behaviour:
- Reset (async, rst=1):
  - gnt=0, gnt_valid=0, gnt_id=0, preempt=0.
  - Priority pointer ptr=0, hold_cnt=0, state=IDLE.
  - Reset mid-grant clears everything immediately, without waiting for clk.
- any_req = or8way(req), computed combinationally.
- Winner = first set bit of req, scanning ptr, ptr+1, ..., ptr+7 mod 8. Computed combinationally, used only at clock edges.
- State IDLE:
  - If any_req=1 at the edge: gnt <= onehot(winner), gnt_id <= winner, hold_cnt <= 0, go to GRANT.
  - Latency: 1 cycle from req rising to gnt.
  - Else stay in IDLE.
- State GRANT, per edge, evaluated in this priority order:
  1. Release: req[gnt_id]=0.
     - ptr <= gnt_id+1 (mod 8).
     - If any_req: direct handoff, no bubble. gnt/gnt_id <= winner searched from gnt_id+1, hold_cnt <= 0, stay in GRANT.
     - Else: gnt <= 0, go to IDLE.
  2. Timeout: HOLD_MAX!=0, hold_cnt==HOLD_MAX-1 and req[gnt_id]=1.
     - ptr <= gnt_id+1, preempt <= 1 for one cycle.
     - Grant the winner searched from gnt_id+1. The current holder is checked last, so it is re-granted if it is the sole requester.
     - hold_cnt <= 0.
  3. Else: hold grant, hold_cnt <= hold_cnt+1.
- ptr changes only on release or timeout, never in IDLE. Fairness is therefore relative to the last granted index.
- hold_cnt width: $clog2(HOLD_MAX+1), minimum 1. It never exceeds HOLD_MAX-1.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_id == index(gnt) whenever gnt_valid=1.
  - preempt is never high for 2 consecutive cycles unless back-to-back timeouts occur (possible only when HOLD_MAX=1).
- Simultaneous events:
  - Release and timeout on the same edge: release wins, preempt=0.
  - New requests arriving while in GRANT do not disturb the current holder.
- Wrap-around: holder at gnt_id=7 gives ptr=0.
- Requests dropped by non-granted requesters: no effect.

Decomposition:
- Package arb_pkg:
  - localparam N_REQ=8.
  - typedef logic [2:0] req_id_t.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- Sub-module rr_pick8: combinational; inputs req[7:0] and start req_id_t; outputs found and id. Instantiated once, with start=ptr in IDLE and start=gnt_id+1 in GRANT.
- Existing or8way instantiated for any_req.

Test Plan:
- Reset then idle: rst pulse with req=00 for 5 cycles -> gnt=00, gnt_valid=0, gnt_id=0, preempt=0 throughout. Assert rst asynchronously while gnt=08 -> gnt=00 before the next edge.
- Single request: req=08 -> gnt=08, gnt_id=3 one cycle later. Drop req -> gnt=00 next cycle, ptr=4.
- Round robin: from reset, req=FF held, each holder drops its bit for one cycle on grant -> grant order 0,1,...,7,0 with no idle bubble between handoffs.
- Wrap and skip: ptr=6, req=41 -> gnt=40 (id 6). Release -> gnt=01 (id 0) on the same edge.
- Timeout (HOLD_MAX=4): req=05 held constantly -> gnt=01 for 4 cycles, then preempt pulse and gnt=04 for 4 cycles, then gnt=01. With req=01 only -> re-granted 01 and preempt pulses every 4 cycles.
- Collision: at hold_cnt=HOLD_MAX-1 the holder drops req on the same edge -> treated as release, preempt=0, next winner granted.
